fx_match_pipe: RTL and testbench
================================

// Module: fx_match_pipe
// PURPOSE
//  Parametrised, pipelined fixed-point format converter (quantization + overflow stages).
//  Maps a Q(IN_W,IN_FRAC) sample to Q(OUT_W,OUT_FRAC) with run-time rounding/saturation modes.
//  Sits between datapath operators wherever formats differ; replaces fixed match+delay pairs.
//  Adds valid/ready flow control and overflow reporting.
// PARAMETERS
//  IN_W      12  input word width (bits)
//  IN_FRAC    8  input fractional bits
//  OUT_W      8  output word width (bits)
//  OUT_FRAC   4  output fractional bits
//  SIGNED     1  1: two's complement both sides; 0: unsigned
//  LATENCY    2  pipeline stages, 1..4 (stage 1 = quantize, last = overflow/output register)
// PORTS
//  i_clk        in   1      clock, rising edge
//  i_rst_n      in   1      synchronous reset, active low
//  i_valid      in   1      input sample valid
//  o_ready      out  1      block accepts sample this cycle
//  i_data       in   IN_W   input sample
//  i_round_mode in   2      0 floor(trunc) 1 half-up 2 half-even 3 toward-zero
//  i_sat_en     in   1      1 saturate, 0 wrap
//  o_valid      out  1      output sample valid
//  i_ready      in   1      downstream accepts output
//  o_data       out  OUT_W  converted sample
//  o_ovf        out  1      overflow occurred on current o_data (qualified by o_valid)
//  o_ovf_sticky out  1      set on any accepted overflowing output; cleared by i_ovf_clr
//  i_ovf_clr    in   1      clear sticky flag
// BEHAVIOUR
//  Reset (i_rst_n=0 at edge): all stage valids, o_valid, o_data, o_ovf, o_ovf_sticky -> 0.
//  Reset mid-stream discards in-flight samples; no output is produced for them.
//  Handshake: advance = !o_valid | i_ready; o_ready = advance (combinational path allowed).
//   Transfer in on i_valid&o_ready; out on o_valid&i_ready. Global stall, no bubble collapse.
//   While stalled, o_data/o_ovf are held stable.
//  Latency: exactly LATENCY advancing cycles from input accept to o_valid.
//  Mode inputs are captured with the sample; mode changes affect only later samples.
//  Quantize: S = IN_FRAC-OUT_FRAC.
//   S<=0: left-shift by -S (zero LSB pad), exact, rounding ignored.
//   S>0: drop S LSBs; intermediate width IN_W-S+1 holds carry. Round increment:
//    floor: 0; half-up: dropped>=half; half-even: dropped>half or (=half & kept LSB=1);
//    toward-zero: 1 only if negative and dropped!=0 (unsigned: same as floor).
//  Overflow: intermediate outside OUT range -> o_ovf=1.
//   sat: clamp to max/min (signed 2^(OUT_W-1)-1 / -2^(OUT_W-1); unsigned 2^OUT_W-1 / 0).
//   wrap: keep OUT_W LSBs. In range: sign-extend (signed) / zero-extend (unsigned), o_ovf=0.
//  Sticky: set on output transfer with o_ovf=1; i_ovf_clr same cycle as set -> set wins.
// TESTING (IN_W=12,IN_FRAC=8,OUT_W=8,OUT_FRAC=4,SIGNED=1,LATENCY=2 unless noted)
//  i_data 0x018 (1.5 LSB) modes 0/1/2/3 -> o_data 0x01/0x02/0x02/0x01, o_ovf=0.
//  i_data 0x028 (2.5 LSB) half-even -> 0x02; half-up -> 0x03.
//  i_data 0xFE8 (-1.5 LSB) modes 0/1/2/3 -> 0xFE/0xFF/0xFE/0xFF.
//  i_data 0x7FF half-up: sat -> 0x7F, wrap -> 0x80, o_ovf=1, o_ovf_sticky=1 until i_ovf_clr.
//  Back-to-back valid, i_ready toggled 1/0 each cycle: output order preserved, held data
//   stable while stalled, none lost/duplicated; o_valid exactly 2 advances after accept.
//  i_rst_n=0 one cycle with 2 samples in flight -> o_valid=0 next cycle, no stale output;
//   also LATENCY=1 and OUT_FRAC>IN_FRAC (0x001 -> LSB pad) sweeps vs. reference model.

Source files
------------

// File: rtl/fx_match_pipe.sv
// Pipelined fixed-point format converter with run-time rounding and saturation.
// Maps Q(IN_W,IN_FRAC) to Q(OUT_W,OUT_FRAC) behind a valid/ready handshake.
module fx_match_pipe #(
    parameter int IN_W     = 12,
    parameter int IN_FRAC  = 8,
    parameter int OUT_W    = 8,
    parameter int OUT_FRAC = 4,
    parameter bit SIGNED   = 1'b1,
    parameter int LATENCY  = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [IN_W-1:0]  i_data,
    input  logic [1:0]       i_round_mode,
    input  logic             i_sat_en,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_data,
    output logic             o_ovf,
    output logic             o_ovf_sticky,
    input  logic             i_ovf_clr
);

    // Shift between formats; positive drops LSBs, negative pads LSBs.
    localparam int S  = IN_FRAC - OUT_FRAC;
    // Quantized width: one spare MSB absorbs the rounding carry.
    localparam int QW = IN_W - S + 1;
    // Compare width: wide enough for both sides plus a sign bit.
    localparam int WW = ((QW > OUT_W) ? QW : OUT_W) + 1;

    localparam logic signed [WW-1:0] MAXV = SIGNED ?
        (WW'(1) << (OUT_W - 1)) - WW'(1) :
        (WW'(1) << OUT_W) - WW'(1);
    localparam logic signed [WW-1:0] MINV = SIGNED ?
        ~((WW'(1) << (OUT_W - 1)) - WW'(1)) :
        '0;

    logic             adv;
    logic             in_neg;
    logic [QW-1:0]    qnt;

    logic             src_v;
    logic             src_s;
    logic [QW-1:0]    src_q;

    logic signed [WW-1:0] qx;
    logic             hi;
    logic             lo;
    logic [OUT_W-1:0] data_d;
    logic             ovf_d;

    logic             valid_q;
    logic [OUT_W-1:0] data_q;
    logic             ovf_q;
    logic             sticky_d;
    logic             sticky_q;

    // Global stall: everything moves only when the output slot frees up.
    assign adv     = !valid_q || i_ready;
    assign o_ready = adv;
    assign in_neg  = SIGNED & i_data[IN_W-1];

    generate
        if (S > 0) begin : g_drop
            localparam logic [S-1:0] HALF = S'(1) << (S - 1);

            logic [S-1:0]      drop;
            logic [IN_W-S-1:0] kept;
            logic              inc;

            assign drop = i_data[S-1:0];
            assign kept = i_data[IN_W-1:S];

            // Rounding increment applied to the floor-shifted value.
            always_comb begin
                inc = 1'b0;
                unique case (i_round_mode)
                    2'd0: inc = 1'b0;
                    2'd1: inc = (drop >= HALF);
                    2'd2: inc = (drop > HALF) ||
                                ((drop == HALF) && kept[0]);
                    2'd3: inc = in_neg && (drop != '0);
                    default: inc = 1'b0;
                endcase
            end

            assign qnt = {in_neg, kept} + QW'(inc);
        end else begin : g_pad
            localparam int P = -S;

            logic unused_mode;

            // Widening is exact, so the rounding mode has no effect.
            assign unused_mode = ^i_round_mode;
            assign qnt = {{(QW - IN_W){in_neg}}, i_data} << P;
        end
    endgenerate

    generate
        if (LATENCY == 1) begin : g_l1
            assign src_v = i_valid;
            assign src_q = qnt;
            assign src_s = i_sat_en;
        end else begin : g_ln
            localparam int N = LATENCY - 1;

            logic [N-1:0]  v_q;
            logic [N-1:0]  s_q;
            logic [QW-1:0] q_q [N];

            // Quantized samples and their saturate flag march in lockstep.
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    v_q <= '0;
                    s_q <= '0;
                    for (int k = 0; k < N; k++) begin
                        q_q[k] <= '0;
                    end
                end else if (adv) begin
                    v_q[0] <= i_valid;
                    s_q[0] <= i_sat_en;
                    q_q[0] <= qnt;
                    for (int k = 1; k < N; k++) begin
                        v_q[k] <= v_q[k-1];
                        s_q[k] <= s_q[k-1];
                        q_q[k] <= q_q[k-1];
                    end
                end
            end

            assign src_v = v_q[N-1];
            assign src_s = s_q[N-1];
            assign src_q = q_q[N-1];
        end
    endgenerate

    // Range check against the output format and clamp or wrap.
    always_comb begin
        qx     = {{(WW - QW){SIGNED & src_q[QW-1]}}, src_q};
        hi     = (qx > MAXV);
        lo     = (qx < MINV);
        ovf_d  = hi || lo;
        data_d = qx[OUT_W-1:0];
        if (src_s && hi) begin
            data_d = MAXV[OUT_W-1:0];
        end else if (src_s && lo) begin
            data_d = MINV[OUT_W-1:0];
        end
    end

    // Output register; data is held while the consumer stalls.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else if (adv) begin
            valid_q <= src_v;
            if (src_v) begin
                data_q <= data_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    // Sticky flag: a transferred overflow beats a same-cycle clear.
    always_comb begin
        sticky_d = sticky_q;
        if (valid_q && i_ready && ovf_q) begin
            sticky_d = 1'b1;
        end else if (i_ovf_clr) begin
            sticky_d = 1'b0;
        end
    end

    // Sticky overflow register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_data       = data_q;
    assign o_ovf        = ovf_q;
    assign o_ovf_sticky = sticky_q;

endmodule

// File: tb/tb_fx_match_pipe.sv
// Scoreboard bench for fx_match_pipe: a Q12.8->Q8.4 two-stage instance
// and a Q12.8->Q12.10 single-stage instance.
module tb_fx_match_pipe;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        i_valid;
    logic        o_ready;
    logic [11:0] i_data;
    logic [1:0]  i_round_mode;
    logic        i_sat_en;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_data;
    logic        o_ovf;
    logic        o_ovf_sticky;
    logic        i_ovf_clr;

    logic        v1;
    logic        rdy1;
    logic [11:0] d1;
    logic [1:0]  m1;
    logic        s1;
    logic        ov1;
    logic        ir1;
    logic [11:0] od1;
    logic        ovf1;
    logic        stk1;
    logic        clr1;

    typedef struct packed {
        logic [11:0] d;
        logic        o;
    } exp_t;

    exp_t sbq[$];
    exp_t sbq1[$];
    int   stq[$];
    int   stq1[$];

    int   checks   = 0;
    int   errors   = 0;
    int   adv_cnt  = 0;
    int   cyc1     = 0;
    int   rdy_mode = 1;
    bit   seen     = 0;
    bit   stk_m    = 0;

    always #5 clk = ~clk;

    fx_match_pipe #(
        .IN_W(12), .IN_FRAC(8), .OUT_W(8), .OUT_FRAC(4),
        .SIGNED(1'b1), .LATENCY(2)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_round_mode(i_round_mode),
        .i_sat_en(i_sat_en), .o_valid(o_valid),
        .i_ready(i_ready), .o_data(o_data),
        .o_ovf(o_ovf), .o_ovf_sticky(o_ovf_sticky),
        .i_ovf_clr(i_ovf_clr)
    );

    fx_match_pipe #(
        .IN_W(12), .IN_FRAC(8), .OUT_W(12), .OUT_FRAC(10),
        .SIGNED(1'b1), .LATENCY(1)
    ) dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_valid(v1), .o_ready(rdy1),
        .i_data(d1), .i_round_mode(m1),
        .i_sat_en(s1), .o_valid(ov1),
        .i_ready(ir1), .o_data(od1),
        .o_ovf(ovf1), .o_ovf_sticky(stk1),
        .i_ovf_clr(clr1)
    );

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] d, input logic [1:0] m,
                        input logic s, input logic [11:0] ed,
                        input logic eo);
        int g;
        bit done;
        sbq.push_back('{d: ed, o: eo});
        i_valid      = 1'b1;
        i_data       = d;
        i_round_mode = m;
        i_sat_en     = s;
        g            = 0;
        done         = 0;
        while (!done) begin
            @(negedge clk);
            if (o_ready) begin
                done = 1;
            end else begin
                g++;
                if (g > 100) begin
                    chk("send_timeout", 0, 1);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic send1(input logic [11:0] d, input logic [1:0] m,
                         input logic s, input logic [11:0] ed,
                         input logic eo);
        sbq1.push_back('{d: ed, o: eo});
        v1 = 1'b1;
        d1 = d;
        m1 = m;
        s1 = s;
        @(posedge clk);
        #1;
        v1 = 1'b0;
    endtask

    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       i_ready = 1'b0;
                1:       i_ready = 1'b1;
                default: i_ready = ~i_ready;
            endcase
        end
    end

    always @(negedge clk) begin : mon
        exp_t e;
        bit   xo;
        xo = 0;
        if (!rst_n) begin
            sbq.delete();
            stq.delete();
            seen  = 0;
            stk_m = 0;
        end else begin
            if (o_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = sbq[0];
                    if (!seen) begin
                        seen = 1;
                        if (stq.size() == 0)
                            chk("latency_nostamp", 1, 0);
                        else
                            chk("latency", adv_cnt - stq[0], 2);
                    end
                    chk("data", int'(o_data), int'(e.d));
                    chk("ovf", int'(o_ovf), int'(e.o));
                    if (i_ready) begin
                        void'(sbq.pop_front());
                        if (stq.size() > 0)
                            void'(stq.pop_front());
                        seen = 0;
                        xo   = e.o;
                    end
                end
            end
            chk("sticky", int'(o_ovf_sticky), int'(stk_m));
            if (xo)
                stk_m = 1;
            else if (i_ovf_clr)
                stk_m = 0;
            if (i_valid && o_ready)
                stq.push_back(adv_cnt);
            if (!o_valid || i_ready)
                adv_cnt++;
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (!rst_n) begin
            sbq1.delete();
            stq1.delete();
        end else begin
            if (ov1) begin
                if (sbq1.size() == 0) begin
                    chk("unexpected_out1", 1, 0);
                end else begin
                    e = sbq1.pop_front();
                    chk("data1", int'(od1), int'(e.d));
                    chk("ovf1", int'(ovf1), int'(e.o));
                    if (stq1.size() == 0)
                        chk("latency1_nostamp", 1, 0);
                    else
                        chk("latency1", cyc1 - stq1.pop_front(), 1);
                end
            end
            if (v1 && rdy1)
                stq1.push_back(cyc1);
            cyc1++;
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst_n        = 1'b0;
        i_valid      = 1'b0;
        i_data       = '0;
        i_round_mode = '0;
        i_sat_en     = 1'b0;
        i_ovf_clr    = 1'b0;
        v1           = 1'b0;
        d1           = '0;
        m1           = '0;
        s1           = 1'b0;
        ir1          = 1'b1;
        clr1         = 1'b0;

        step(3);
        @(negedge clk);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_data", int'(o_data), 0);
        chk("rst_ovf", int'(o_ovf), 0);
        chk("rst_sticky", int'(o_ovf_sticky), 0);
        chk("rst_valid1", int'(ov1), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);

        // Rounding modes on +/-1.5 and 2.5 LSB
        send(12'h018, 2'd0, 1'b1, 12'h001, 1'b0);
        send(12'h018, 2'd1, 1'b1, 12'h002, 1'b0);
        send(12'h018, 2'd2, 1'b1, 12'h002, 1'b0);
        send(12'h018, 2'd3, 1'b1, 12'h001, 1'b0);
        send(12'h028, 2'd2, 1'b1, 12'h002, 1'b0);
        send(12'h028, 2'd1, 1'b1, 12'h003, 1'b0);
        send(12'hFE8, 2'd0, 1'b1, 12'h0FE, 1'b0);
        send(12'hFE8, 2'd1, 1'b1, 12'h0FF, 1'b0);
        send(12'hFE8, 2'd2, 1'b1, 12'h0FE, 1'b0);
        send(12'hFE8, 2'd3, 1'b1, 12'h0FF, 1'b0);
        send(12'h801, 2'd3, 1'b1, 12'h081, 1'b0);
        send(12'h801, 2'd0, 1'b1, 12'h080, 1'b0);
        send(12'h800, 2'd3, 1'b1, 12'h080, 1'b0);
        send(12'h7F7, 2'd1, 1'b1, 12'h07F, 1'b0);
        step(4);

        // Overflow, saturate vs wrap, sticky flag
        send(12'h7FF, 2'd1, 1'b1, 12'h07F, 1'b1);
        send(12'h7FF, 2'd1, 1'b0, 12'h080, 1'b1);
        send(12'h7F8, 2'd2, 1'b0, 12'h080, 1'b1);
        send(12'h800, 2'd0, 1'b1, 12'h080, 1'b0);
        step(6);
        chk("sticky_held", int'(o_ovf_sticky), 1);
        i_ovf_clr = 1'b1;
        step(1);
        i_ovf_clr = 1'b0;
        step(2);
        chk("sticky_cleared", int'(o_ovf_sticky), 0);

        // Clear held high across an overflow transfer
        i_ovf_clr = 1'b1;
        send(12'h7FF, 2'd1, 1'b1, 12'h07F, 1'b1);
        step(8);
        i_ovf_clr = 1'b0;
        chk("sticky_after_clr", int'(o_ovf_sticky), 0);

        // Back-to-back with downstream ready toggling
        rdy_mode = 2;
        send(12'h018, 2'd1, 1'b1, 12'h002, 1'b0);
        send(12'h028, 2'd0, 1'b1, 12'h002, 1'b0);
        send(12'hFE8, 2'd3, 1'b1, 12'h0FF, 1'b0);
        send(12'h7FF, 2'd1, 1'b0, 12'h080, 1'b1);
        send(12'h100, 2'd0, 1'b1, 12'h010, 1'b0);
        send(12'hF00, 2'd2, 1'b1, 12'h0F0, 1'b0);
        send(12'h028, 2'd2, 1'b1, 12'h002, 1'b0);
        send(12'h801, 2'd3, 1'b1, 12'h081, 1'b0);
        rdy_mode = 1;
        step(10);

        // Reset with two samples in flight
        rdy_mode = 0;
        step(3);
        send(12'h018, 2'd1, 1'b1, 12'h002, 1'b0);
        send(12'h028, 2'd1, 1'b1, 12'h003, 1'b0);
        rst_n = 1'b0;
        step(1);
        rst_n    = 1'b1;
        rdy_mode = 1;
        @(negedge clk);
        chk("rst_flush_valid", int'(o_valid), 0);
        chk("rst_flush_sticky", int'(o_ovf_sticky), 0);
        step(6);

        // Single-stage instance, widening with LSB pad
        send1(12'h001, 2'd1, 1'b1, 12'h004, 1'b0);
        send1(12'hFFF, 2'd0, 1'b1, 12'hFFC, 1'b0);
        send1(12'h200, 2'd2, 1'b1, 12'h7FF, 1'b1);
        send1(12'h200, 2'd3, 1'b0, 12'h800, 1'b1);
        send1(12'hE00, 2'd0, 1'b1, 12'h800, 1'b0);
        send1(12'h1FF, 2'd1, 1'b0, 12'h7FC, 1'b0);
        step(2);

        g = 0;
        while ((sbq.size() + sbq1.size()) != 0 && g < 100) begin
            step(1);
            g++;
        end
        chk("drain", sbq.size() + sbq1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
